fighter_action_fsm: RTL

Per-player action sequencer sitting directly downstream of the keycode decoder: consumes one player's decoded key levels (left, right, attack 1, attack 2) plus a hit notification from collision logic, and produces that fighter's action state, movement direction, hitbox enable and animation frame index for the sprite/motion logic. All state advances once per video frame, on a tick derived from the VGA frame clock. Two instances exist, one per player.

---
 rtl/fighter_pkg.sv | 23 ++
 rtl/frame_tick_gen.sv | 28 ++
 rtl/fighter_action_fsm.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared action encoding and helpers for the fighter sequencer
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK_L  = 3'd1,
    WALK_R  = 3'd2,
    WINDUP  = 3'd3,
    ACTIVE  = 3'd4,
    RECOVER = 3'd5,
    STUN    = 3'd6
  } action_t;

  localparam logic [1:0] MOVE_NONE  = 2'b00;
  localparam logic [1:0] MOVE_LEFT  = 2'b01;
  localparam logic [1:0] MOVE_RIGHT = 2'b10;

  // States in which the fighter is free to start an attack or walk
  function automatic logic is_free(input action_t s);
    return (s == IDLE) || (s == WALK_L) || (s == WALK_R);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - synchronizes the VGA frame clock and emits one tick per frame
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchronizer followed by a previous-value flop for rising-edge detect
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/fighter_action_fsm.sv
// rtl/fighter_action_fsm.sv - per-player action sequencer advancing once per video frame
module fighter_action_fsm
  import fighter_pkg::*;
#(
  parameter int ATK1_WINDUP  = 4,
  parameter int ATK1_ACTIVE  = 3,
  parameter int ATK1_RECOVER = 6,
  parameter int ATK2_WINDUP  = 6,
  parameter int ATK2_ACTIVE  = 4,
  parameter int ATK2_RECOVER = 10,
  parameter int STUN_FRAMES  = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       left_on,
  input  logic       right_on,
  input  logic       atk1_on,
  input  logic       atk2_on,
  input  logic       hit_in,
  output logic [2:0] state,
  output logic       atk_sel,
  output logic       hitbox_en,
  output logic [1:0] move_dir,
  output logic [3:0] anim_frame,
  output logic       frame_tick
);

  action_t    state_q, state_d;
  logic [3:0] anim_q, anim_d;
  logic       sel_q, sel_d;
  logic       pend1_q, pend1_d;
  logic       pend2_q, pend2_d;
  logic       pend_hit_q, pend_hit_d;
  logic       atk1_prev_q, atk2_prev_q;
  logic       frame_tick_q;
  logic       tick;

  action_t    free_state;
  logic       free_sel;
  logic [3:0] last_frame;
  logic       set1, set2;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // Next-state, frame counter and pending-request logic; only a tick moves the state
  always_comb begin
    state_d    = state_q;
    anim_d     = anim_q;
    sel_d      = sel_q;
    free_state = IDLE;
    free_sel   = sel_q;
    last_frame = 4'd0;

    // Attack edges only register while the fighter is free; a tick consumes older
    // pends, while an edge landing on the tick cycle survives for the next frame
    set1       = atk1_on & ~atk1_prev_q & is_free(state_q);
    set2       = atk2_on & ~atk2_prev_q & is_free(state_q);
    pend1_d    = tick ? set1   : (pend1_q | set1);
    pend2_d    = tick ? set2   : (pend2_q | set2);
    pend_hit_d = tick ? hit_in : (pend_hit_q | hit_in);

    // Decision shared by IDLE/WALK and the exit of RECOVER/STUN
    if (pend1_q) begin
      free_state = WINDUP;
      free_sel   = 1'b0;
    end else if (pend2_q) begin
      free_state = WINDUP;
      free_sel   = 1'b1;
    end else if (left_on ^ right_on) begin
      free_state = left_on ? WALK_L : WALK_R;
    end

    case (state_q)
      WINDUP:  last_frame = sel_q ? 4'(ATK2_WINDUP - 1)  : 4'(ATK1_WINDUP - 1);
      ACTIVE:  last_frame = sel_q ? 4'(ATK2_ACTIVE - 1)  : 4'(ATK1_ACTIVE - 1);
      RECOVER: last_frame = sel_q ? 4'(ATK2_RECOVER - 1) : 4'(ATK1_RECOVER - 1);
      STUN:    last_frame = 4'(STUN_FRAMES - 1);
      default: last_frame = 4'd0;
    endcase

    if (tick) begin
      if (pend_hit_q) begin
        state_d = STUN;
        anim_d  = 4'd0;
      end else begin
        case (state_q)
          IDLE, WALK_L, WALK_R: begin
            state_d = free_state;
            sel_d   = free_sel;
            anim_d  = (free_state == state_q) ? anim_q + 4'd1 : 4'd0;
          end
          WINDUP, ACTIVE: begin
            if (anim_q == last_frame) begin
              state_d = (state_q == WINDUP) ? ACTIVE : RECOVER;
              anim_d  = 4'd0;
            end else begin
              anim_d  = anim_q + 4'd1;
            end
          end
          RECOVER, STUN: begin
            if (anim_q == last_frame) begin
              state_d = free_state;
              sel_d   = free_sel;
              anim_d  = 4'd0;
            end else begin
              anim_d  = anim_q + 4'd1;
            end
          end
          default: begin
            state_d = IDLE;
            anim_d  = 4'd0;
          end
        endcase
      end
    end
  end

  // State, counters, pends and key-history registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      anim_q       <= 4'd0;
      sel_q        <= 1'b0;
      pend1_q      <= 1'b0;
      pend2_q      <= 1'b0;
      pend_hit_q   <= 1'b0;
      atk1_prev_q  <= 1'b0;
      atk2_prev_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      anim_q       <= anim_d;
      sel_q        <= sel_d;
      pend1_q      <= pend1_d;
      pend2_q      <= pend2_d;
      pend_hit_q   <= pend_hit_d;
      atk1_prev_q  <= atk1_on;
      atk2_prev_q  <= atk2_on;
      frame_tick_q <= tick;
    end
  end

  assign state      = state_q;
  assign atk_sel    = sel_q;
  assign anim_frame = anim_q;
  assign frame_tick = frame_tick_q;
  assign hitbox_en  = (state_q == ACTIVE);
  assign move_dir   = (state_q == WALK_L) ? MOVE_LEFT :
                      (state_q == WALK_R) ? MOVE_RIGHT : MOVE_NONE;

endmodule
